// File: rtl/dreg_bank_pkg.sv
// dreg_bank shared constants and helpers.
// Default geometry and the select-width function.
package dreg_bank_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_RESET_VAL = 0;

  // select width for n channels, never below 1
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dreg_bank_if.sv
// dreg_bank bus: write/clear/read controls and outputs.
// DREG_BANK_PARITY_EN adds par_err.
interface dreg_bank_if
  import dreg_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  localparam int SW = sel_w(CHANNELS);

  logic                      en;
  logic [SW-1:0]             sel;
  logic [WIDTH-1:0]          data;
  logic                      clr_ch;
  logic                      hold;
  logic                      rd_en;
  logic [SW-1:0]             rd_sel;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*WIDTH-1:0] q_n;
  logic [CHANNELS-1:0]       valid;
  logic [WIDTH-1:0]          rd_data;
  logic                      rd_vld;
  logic                      sel_err;
`ifdef DREG_BANK_PARITY_EN
  logic                      par_err;
`endif

  modport master (
    output en, sel, data, clr_ch, hold,
    output rd_en, rd_sel,
    input  q, q_n, valid,
    input  rd_data, rd_vld, sel_err
`ifdef DREG_BANK_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  en, sel, data, clr_ch, hold,
    input  rd_en, rd_sel,
    output q, q_n, valid,
    output rd_data, rd_vld, sel_err
`ifdef DREG_BANK_PARITY_EN
    , output par_err
`endif
  );

endinterface

// File: rtl/dreg_bank_cell.sv
// dreg_cell: one channel of value, valid, optional parity.
// DREG_BANK_PARITY_EN stores an even-parity bit per channel.
module dreg_cell #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             ld_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
`ifdef DREG_BANK_PARITY_EN
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] val_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] val_q;
  logic             vld_q;
`ifdef DREG_BANK_PARITY_EN
  logic             par_q;
`endif

  // clear beats load; hold freezes both
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= RESET_VAL;
      vld_q <= 1'b0;
`ifdef DREG_BANK_PARITY_EN
      par_q <= ^RESET_VAL;
`endif
    end else if (!hold_i) begin
      if (clr_i) begin
        val_q <= RESET_VAL;
        vld_q <= 1'b0;
`ifdef DREG_BANK_PARITY_EN
        par_q <= ^RESET_VAL;
`endif
      end else if (ld_i) begin
        val_q <= d_i;
        vld_q <= 1'b1;
`ifdef DREG_BANK_PARITY_EN
        par_q <= ^d_i;
`endif
      end
    end
  end

  assign val_o = val_q;
  assign vld_o = vld_q;
`ifdef DREG_BANK_PARITY_EN
  assign par_o = par_q;
`endif

endmodule

// File: rtl/dreg_bank.sv
// dreg_bank: CHANNELS x WIDTH register bank, one read port.
// DREG_BANK_PARITY_EN enables per-channel parity and par_err.
module dreg_bank
  import dreg_bank_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               CHANNELS  = DEF_CHANNELS,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic       clk,
  input  logic       reset,
  dreg_bank_if.slave bus
);

  localparam int            SW  = sel_w(CHANNELS);
  localparam logic [SW:0]   NCH = (SW+1)'(CHANNELS);

  logic                      sel_ok;
  logic                      rd_ok;
  logic [WIDTH-1:0]          val [CHANNELS];
  logic [CHANNELS-1:0]       vld;
  logic [CHANNELS*WIDTH-1:0] q_flat;
`ifdef DREG_BANK_PARITY_EN
  logic [CHANNELS-1:0]       par;
  logic                      par_err_d, par_err_q;
`endif

  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic             rd_vld_d, rd_vld_q;
  logic             sel_err_d, sel_err_q;

  assign sel_ok = {1'b0, bus.sel} < NCH;
  assign rd_ok  = {1'b0, bus.rd_sel} < NCH;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    logic hit;
    assign hit = sel_ok && (bus.sel == SW'(i));
    dreg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .hold_i (bus.hold),
      .ld_i   (bus.en && hit),
      .clr_i  (bus.clr_ch && hit),
      .d_i    (bus.data),
`ifdef DREG_BANK_PARITY_EN
      .par_o  (par[i]),
`endif
      .val_o  (val[i]),
      .vld_o  (vld[i])
    );
    assign q_flat[i*WIDTH +: WIDTH] = val[i];
  end

  assign bus.q     = q_flat;
  assign bus.q_n   = ~q_flat;
  assign bus.valid = vld;

  // read mux samples pre-write values; errors flag bad selects
  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = bus.rd_en && rd_ok;
    sel_err_d = ((bus.en || bus.clr_ch) && !sel_ok)
             || (bus.rd_en && !rd_ok);
    if (rd_vld_d) rd_data_d = val[bus.rd_sel];
`ifdef DREG_BANK_PARITY_EN
    par_err_d = 1'b0;
    if (rd_vld_d)
      par_err_d = (^val[bus.rd_sel]) != par[bus.rd_sel];
`endif
  end

  // registered read port and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      sel_err_q <= 1'b0;
`ifdef DREG_BANK_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      sel_err_q <= sel_err_d;
`ifdef DREG_BANK_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.sel_err = sel_err_q;
`ifdef DREG_BANK_PARITY_EN
  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_dreg_bank.sv
// Directed bench for dreg_bank: 4-channel and 3-channel builds.
// DREG_BANK_PARITY_EN adds a parity-error scenario.
module tb_dreg_bank;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dreg_bank_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
  dreg_bank_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

  dreg_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(8'h00)) d4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  dreg_bank #(.WIDTH(8), .CHANNELS(3), .RESET_VAL(8'h5A)) d3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    b4.en = 0; b4.sel = 0; b4.data = 0; b4.clr_ch = 0;
    b4.hold = 0; b4.rd_en = 0; b4.rd_sel = 0;
  endtask

  task automatic idle3();
    b3.en = 0; b3.sel = 0; b3.data = 0; b3.clr_ch = 0;
    b3.hold = 0; b3.rd_en = 0; b3.rd_sel = 0;
  endtask

  initial begin
    idle4();
    idle3();
    reset = 1;
    tick();
    tick();

    chk("rst_q", b4.q, 32'h0000_0000);
    chk("rst_qn", b4.q_n, 32'hFFFF_FFFF);
    chk("rst_valid", 32'(b4.valid), 32'h0);
    chk("rst_rdvld", 32'(b4.rd_vld), 32'h0);
    chk("rst_rddata", 32'(b4.rd_data), 32'h0);
    chk("rst_selerr", 32'(b4.sel_err), 32'h0);
    chk("rst3_q", 32'(b3.q), 32'h5A5A5A);

    // first access in the cycle reset drops
    reset = 0;
    b4.en = 1; b4.sel = 2; b4.data = 8'hA5;
    tick();
    chk("wr2_q", b4.q, 32'h00A5_0000);
    chk("wr2_qn", b4.q_n, 32'hFF5A_FFFF);
    chk("wr2_valid", 32'(b4.valid), 32'h4);

    // read-before-write on same channel
    b4.sel = 1; b4.data = 8'h3C;
    b4.rd_en = 1; b4.rd_sel = 1;
    tick();
    chk("rbw_data", 32'(b4.rd_data), 32'h00);
    chk("rbw_vld", 32'(b4.rd_vld), 32'h1);
    chk("rbw_q", b4.q, 32'h00A5_3C00);
    chk("rbw_valid", 32'(b4.valid), 32'h6);

    b4.en = 0;
    tick();
    chk("rd1_data", 32'(b4.rd_data), 32'h3C);
    chk("rd1_vld", 32'(b4.rd_vld), 32'h1);

    b4.rd_en = 0;
    tick();
    chk("rdoff_vld", 32'(b4.rd_vld), 32'h0);
    chk("rdoff_data", 32'(b4.rd_data), 32'h3C);

    // clear wins over write
    b4.en = 1; b4.clr_ch = 1; b4.sel = 1; b4.data = 8'h77;
    tick();
    chk("clr_q", b4.q, 32'h00A5_0000);
    chk("clr_valid", 32'(b4.valid), 32'h4);

    // hold blocks write
    b4.clr_ch = 0; b4.hold = 1; b4.sel = 0; b4.data = 8'hFF;
    tick();
    chk("hold_wr_q", b4.q, 32'h00A5_0000);
    chk("hold_wr_valid", 32'(b4.valid), 32'h4);

    // hold blocks clear, read still served
    b4.en = 0; b4.clr_ch = 1; b4.sel = 2;
    b4.rd_en = 1; b4.rd_sel = 2;
    tick();
    chk("hold_clr_q", b4.q, 32'h00A5_0000);
    chk("hold_clr_valid", 32'(b4.valid), 32'h4);
    chk("hold_rd_data", 32'(b4.rd_data), 32'hA5);
    chk("hold_rd_vld", 32'(b4.rd_vld), 32'h1);

    // other channels untouched by a write
    idle4();
    b4.en = 1; b4.sel = 3; b4.data = 8'hC3;
    tick();
    chk("wr3_q", b4.q, 32'hC3A5_0000);
    chk("wr3_qn", b4.q_n, 32'h3C5A_FFFF);
    chk("wr3_valid", 32'(b4.valid), 32'hC);

    // 3-channel bank: range errors
    idle4();
    b3.en = 1; b3.sel = 0; b3.data = 8'h11;
    tick();
    chk("c3_wr_q", 32'(b3.q), 32'h5A5A11);
    chk("c3_wr_valid", 32'(b3.valid), 32'h1);
    chk("c3_wr_err", 32'(b3.sel_err), 32'h0);

    b3.sel = 3; b3.data = 8'h99;
    tick();
    chk("c3_bad_err", 32'(b3.sel_err), 32'h1);
    chk("c3_bad_q", 32'(b3.q), 32'h5A5A11);
    chk("c3_bad_valid", 32'(b3.valid), 32'h1);

    idle3();
    tick();
    chk("c3_err_drop", 32'(b3.sel_err), 32'h0);

    b3.rd_en = 1; b3.rd_sel = 3;
    tick();
    chk("c3_badrd_vld", 32'(b3.rd_vld), 32'h0);
    chk("c3_badrd_err", 32'(b3.sel_err), 32'h1);

    b3.rd_sel = 0;
    tick();
    chk("c3_rd_vld", 32'(b3.rd_vld), 32'h1);
    chk("c3_rd_data", 32'(b3.rd_data), 32'h11);
    chk("c3_rd_err", 32'(b3.sel_err), 32'h0);

    idle3();
    b3.clr_ch = 1; b3.sel = 0;
    tick();
    chk("c3_clr_q", 32'(b3.q), 32'h5A5A5A);
    chk("c3_clr_valid", 32'(b3.valid), 32'h0);
    idle3();

    // reset in the cycle after a read request
    b4.rd_en = 1; b4.rd_sel = 3;
    tick();
    chk("pre_rst_data", 32'(b4.rd_data), 32'hC3);
    b4.rd_sel = 2;
    reset = 1;
    tick();
    chk("mid_rst_vld", 32'(b4.rd_vld), 32'h0);
    chk("mid_rst_data", 32'(b4.rd_data), 32'h0);
    chk("mid_rst_q", b4.q, 32'h0);
    chk("mid_rst_valid", 32'(b4.valid), 32'h0);
    reset = 0;
    idle4();

`ifdef DREG_BANK_PARITY_EN
    b4.en = 1; b4.sel = 0; b4.data = 8'h01;
    tick();
    b4.en = 0;
    force d4.g_cell[0].u_cell.par_q = 1'b0;
    b4.rd_en = 1; b4.rd_sel = 0;
    tick();
    chk("par_bad_err", 32'(b4.par_err), 32'h1);
    chk("par_bad_vld", 32'(b4.rd_vld), 32'h1);
    release d4.g_cell[0].u_cell.par_q;
    b4.rd_en = 0;
    b4.en = 1; b4.data = 8'h01;
    tick();
    b4.en = 0;
    b4.rd_en = 1;
    tick();
    chk("par_ok_err", 32'(b4.par_err), 32'h0);
    chk("par_ok_vld", 32'(b4.rd_vld), 32'h1);
    idle4();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
